// File: rtl/wkt_button_reader.sv
`default_nettype none
// ============================================================================
// Module      : wkt_button_reader
// Description : Two-flop synchroniser and per-pin debouncer for board inputs,
//               with one-cycle press/release pulses and a small event FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module wkt_button_reader #(
    parameter int NBITS           = 8,
    parameter int DEBOUNCE_CYCLES = 16000,
    parameter int CTRW            = 14,
    parameter int LGFIFO          = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NBITS-1:0]     i_pins,
    output logic [NBITS-1:0]     o_state,
    output logic [NBITS-1:0]     o_press,
    output logic [NBITS-1:0]     o_release,
    output logic                 o_evt_valid,
    output logic [2*NBITS-1:0]   o_evt_data,
    input  logic                 i_evt_ready,
    output logic                 o_overflow
);

    localparam int                c_DEPTH    = 1 << LGFIFO;
    localparam logic [CTRW-1:0]   c_CNT_LAST = CTRW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LGFIFO:0]   c_FULL     = (LGFIFO + 1)'(c_DEPTH);

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic [NBITS-1:0] r_sync1;
    logic [NBITS-1:0] r_sync2;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_pins;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: a pin must disagree with o_state for DEBOUNCE_CYCLES
    // consecutive samples before the new level is accepted.
    // ------------------------------------------------------------------
    logic [CTRW-1:0]  r_cnt      [NBITS];
    logic [CTRW-1:0]  w_cnt_nxt  [NBITS];
    logic [NBITS-1:0] w_state_nxt;
    logic [NBITS-1:0] w_press_nxt;
    logic [NBITS-1:0] w_release_nxt;

    always_comb begin
        w_state_nxt   = o_state;
        w_press_nxt   = '0;
        w_release_nxt = '0;
        for (int i = 0; i < NBITS; i++) begin
            w_cnt_nxt[i] = '0;
            if (r_sync2[i] != o_state[i]) begin
                if (r_cnt[i] == c_CNT_LAST) begin
                    w_state_nxt[i]   = r_sync2[i];
                    w_press_nxt[i]   = r_sync2[i];
                    w_release_nxt[i] = ~r_sync2[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_state   <= '0;
            o_press   <= '0;
            o_release <= '0;
            for (int i = 0; i < NBITS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            o_state   <= w_state_nxt;
            o_press   <= w_press_nxt;
            o_release <= w_release_nxt;
            for (int i = 0; i < NBITS; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO. Simultaneous edges merge into one entry, written on the
    // same edge that raises the pulses.
    // ------------------------------------------------------------------
    logic [2*NBITS-1:0] r_mem [c_DEPTH];
    logic [LGFIFO-1:0]  r_wr_ptr;
    logic [LGFIFO-1:0]  r_rd_ptr;
    logic [LGFIFO:0]    r_count;

    logic               w_push;
    logic [2*NBITS-1:0] w_push_data;
    logic               w_pop;
    logic               w_full;
    logic               w_wr_en;
    logic               w_drop;
    logic [LGFIFO-1:0]  w_rd_ptr_nxt;
    logic [LGFIFO:0]    w_count_after_pop;
    logic               w_head_avail;

    assign w_push            = |(w_press_nxt | w_release_nxt);
    assign w_push_data       = {w_press_nxt, w_release_nxt};
    assign w_pop             = o_evt_valid & i_evt_ready;
    assign w_full            = (r_count == c_FULL);
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_wr_en           = w_push & (~w_full | w_pop);
    assign w_drop            = w_push & w_full & ~w_pop;
    assign w_rd_ptr_nxt      = r_rd_ptr + LGFIFO'(w_pop);
    assign w_count_after_pop = r_count - (LGFIFO + 1)'(w_pop);
    assign w_head_avail      = (w_count_after_pop != '0);

    always_ff @(posedge i_clk) begin
        if (!i_reset && w_wr_en) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    // Head register looks only at pre-edge contents, so a fresh push is
    // never visible until the following cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            o_evt_valid <= 1'b0;
            o_evt_data  <= '0;
            o_overflow  <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_count     <= w_count_after_pop + (LGFIFO + 1)'(w_wr_en);
            o_evt_valid <= w_head_avail;
            o_evt_data  <= w_head_avail ? r_mem[w_rd_ptr_nxt] : '0;
            if (w_drop) begin
                o_overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wkt_button_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_wkt_button_reader
// Description : Directed self-checking bench for wkt_button_reader with a
//               scoreboard queue of expected FIFO events.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wkt_button_reader;

    localparam int NBITS  = 8;
    localparam int DEB    = 4;
    localparam int CTRW   = 14;
    localparam int LGFIFO = 2;

    logic             clk;
    logic             rst;
    logic [NBITS-1:0] pins;
    logic [NBITS-1:0] state;
    logic [NBITS-1:0] press;
    logic [NBITS-1:0] release_p;
    logic             evt_valid;
    logic [2*NBITS-1:0] evt_data;
    logic             evt_ready;
    logic             overflow;

    int               n_assert = 0;
    int               n_fail   = 0;
    logic [15:0]      exp_q [$];
    logic [15:0]      e_tmp;
    logic             seen;

    wkt_button_reader #(
        .NBITS           (NBITS),
        .DEBOUNCE_CYCLES (DEB),
        .CTRW            (CTRW),
        .LGFIFO          (LGFIFO)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_pins      (pins),
        .o_state     (state),
        .o_press     (press),
        .o_release   (release_p),
        .o_evt_valid (evt_valid),
        .o_evt_data  (evt_data),
        .i_evt_ready (evt_ready),
        .o_overflow  (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a head entry, compare it with the scoreboard, pop it.
    task automatic take_evt(input string tag);
        int w;
        logic [15:0] e;
        w = 0;
        while (!evt_valid && w < 40) begin
            step();
            w++;
        end
        chk({tag, "_valid"}, 16'(evt_valid), 16'h0001);
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = 16'hdead;
        chk({tag, "_data"}, evt_data, e);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        pins      = '0;
        evt_ready = 1'b0;
        step_n(2);
        rst = 1'b0;

        chk("rst_state",    16'(state),     16'h0);
        chk("rst_press",    16'(press),     16'h0);
        chk("rst_release",  16'(release_p), 16'h0);
        chk("rst_valid",    16'(evt_valid), 16'h0);
        chk("rst_data",     evt_data,       16'h0);
        chk("rst_overflow", 16'(overflow),  16'h0);

        // Single press: state/pulse at edge 5, event visible at edge 6
        pins = 8'h01;
        exp_q.push_back(16'h0100);
        for (int e = 0; e <= 5; e++) begin
            step();
            chk($sformatf("t1_state_e%0d", e), 16'(state), (e == 5) ? 16'h0001 : 16'h0000);
            chk($sformatf("t1_press_e%0d", e), 16'(press), (e == 5) ? 16'h0001 : 16'h0000);
            chk($sformatf("t1_valid_e%0d", e), 16'(evt_valid), 16'h0000);
        end
        step();
        chk("t1_press_e6", 16'(press), 16'h0000);
        chk("t1_valid_e6", 16'(evt_valid), 16'h0001);
        take_evt("t1");
        chk("t1_empty_after_pop", 16'(evt_valid), 16'h0000);

        // Glitch on bit 3 shorter than the debounce window
        pins = 8'h09;
        step_n(3);
        pins = 8'h01;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (evt_valid || state != 8'h01 || press != 8'h00) seen = 1'b1;
        end
        chk("t2_glitch_ignored", 16'(seen), 16'h0000);

        // Simultaneous edges merge into one entry
        pins = 8'h00;
        exp_q.push_back(16'h0001);
        take_evt("t3_rel0");
        pins = 8'h81;
        exp_q.push_back(16'h8100);
        take_evt("t3_dual_press");
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (evt_valid) seen = 1'b1;
        end
        chk("t3_single_entry", 16'(seen), 16'h0000);
        chk("t3_state_81", 16'(state), 16'h0081);
        pins = 8'h01;
        exp_q.push_back(16'h0080);
        take_evt("t3_rel7");
        chk("t3_state_01", 16'(state), 16'h0001);

        // Overflow: six events with no consumer, depth four
        for (int n = 0; n < 6; n++) begin
            pins = (n % 2 == 0) ? 8'h03 : 8'h01;
            if (n < 4) exp_q.push_back((n % 2 == 0) ? 16'h0200 : 16'h0002);
            step_n(8);
            if (n == 3) chk("t4_ovf_before", 16'(overflow), 16'h0000);
            if (n == 4) chk("t4_ovf_after5", 16'(overflow), 16'h0001);
        end
        chk("t4_ovf_sticky", 16'(overflow), 16'h0001);
        chk("t4_head_stable", evt_data, 16'h0200);
        for (int n = 0; n < 4; n++) take_evt($sformatf("t4_drain%0d", n));
        step_n(2);
        chk("t4_empty", 16'(evt_valid), 16'h0000);
        chk("t4_ovf_held", 16'(overflow), 16'h0001);

        // Full FIFO with push and pop on the same edge
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        chk("t5_rst_ovf", 16'(overflow), 16'h0000);
        chk("t5_rst_state", 16'(state), 16'h0000);
        exp_q.push_back(16'h0100);
        step_n(8);
        pins = 8'h05; exp_q.push_back(16'h0400); step_n(8);
        pins = 8'h01; exp_q.push_back(16'h0004); step_n(8);
        pins = 8'h05; exp_q.push_back(16'h0400); step_n(8);
        chk("t5_full_ovf", 16'(overflow), 16'h0000);
        chk("t5_full_valid", 16'(evt_valid), 16'h0001);
        pins = 8'h01;
        step_n(5);
        e_tmp = exp_q.pop_front();
        chk("t5_popped_oldest", evt_data, e_tmp);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        exp_q.push_back(16'h0004);
        chk("t5_release_pulse", 16'(release_p), 16'h0004);
        chk("t5_no_overflow", 16'(overflow), 16'h0000);
        for (int n = 0; n < 4; n++) take_evt($sformatf("t5_drain%0d", n));
        step_n(2);
        chk("t5_empty", 16'(evt_valid), 16'h0000);

        // Reset in the middle of a debounce and with two queued entries
        pins = 8'h03; exp_q.push_back(16'h0200); step_n(8);
        pins = 8'h01; exp_q.push_back(16'h0002); step_n(8);
        chk("t6_queued", 16'(evt_valid), 16'h0001);
        pins = 8'h09;
        step_n(4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        chk("t6_state",    16'(state),     16'h0);
        chk("t6_press",    16'(press),     16'h0);
        chk("t6_release",  16'(release_p), 16'h0);
        chk("t6_valid",    16'(evt_valid), 16'h0);
        chk("t6_data",     evt_data,       16'h0);
        chk("t6_overflow", 16'(overflow),  16'h0);
        step_n(5);
        chk("t6_state_pending", 16'(state), 16'h0000);
        step();
        chk("t6_state_redeb", 16'(state), 16'h0009);
        chk("t6_press_redeb", 16'(press), 16'h0009);
        exp_q.push_back(16'h0900);
        take_evt("t6_evt");

        // Pop request on an empty FIFO is ignored
        evt_ready = 1'b1;
        step_n(3);
        chk("t7_empty_pop_valid", 16'(evt_valid), 16'h0000);
        chk("t7_empty_pop_data", evt_data, 16'h0000);
        evt_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
